// File: rtl/dp_ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of the RAM stream reader.
// master is the reader's view; slave is the view of its environment.
interface dp_ram_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, length, ram_q, m_ready,
    output busy, done, ram_addr, ram_we, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, ram_q, m_ready,
    input  busy, done, ram_addr, ram_we, m_data, m_valid
  );
endinterface

// File: rtl/dp_ram_stream_reader.sv
// Burst read sequencer for the feature-map RAM.
// Absorbs the RAM read latency and streams words out through a credit-protected skid FIFO.
module dp_ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dp_ram_stream_reader_if.master bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
  localparam int unsigned INFL_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned CRED_W = CNT_W + INFL_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                 state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
  logic [LEN_W-1:0]       rem_q, rem_nxt;
  logic [RD_LATENCY-1:0]  pipe_q, pipe_nxt;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_nxt;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_nxt;
  logic [DATA_WIDTH-1:0]  m_data_q, head_nxt;
  logic                   m_valid_q;
  logic                   busy_q;
  logic                   done_q, done_nxt;
  logic                   issue, issue_nxt, push, pop;
  logic [INFL_W-1:0]      infl, infl_nxt;

  // Next-state, issue credit and FIFO bookkeeping
  always_comb begin
    state_nxt = state_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    issue     = 1'b0;
    push      = pipe_q[RD_LATENCY-1];
    pop       = m_valid_q & bus.m_ready;
    infl      = '0;
    infl_nxt  = '0;

    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      infl = infl + INFL_W'(pipe_q[i]);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            state_nxt = S_READ;
            addr_nxt  = bus.base_addr;
            rem_nxt   = bus.length;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        issue = (rem_q != '0) &&
                ((CRED_W'(infl) + CRED_W'(cnt_q)) < CRED_W'(FIFO_DEPTH));
        if (issue) begin
          addr_nxt = addr_q + 1'b1;
          rem_nxt  = rem_q - 1'b1;
        end
      end
      default: ;
    endcase

    pipe_nxt[0] = issue;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_nxt[i] = pipe_q[i-1];
    end
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      infl_nxt = infl_nxt + INFL_W'(pipe_nxt[i]);
    end

    cnt_nxt    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_nxt = wr_ptr_q + PTR_W'(push);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(pop);

    // Finish on the edge of the final handoff so done follows it by exactly one cycle
    if ((state_q != S_IDLE) && (rem_nxt == '0)) begin
      if ((pipe_nxt == '0) && (cnt_nxt == '0)) begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = S_DRAIN;
      end
    end

    // ram_addr is registered, so load it one edge ahead of the cycle that issues
    issue_nxt = (state_nxt == S_READ) && (rem_nxt != '0) &&
                ((CRED_W'(infl_nxt) + CRED_W'(cnt_nxt)) < CRED_W'(FIFO_DEPTH));
    ram_addr_nxt = issue_nxt ? addr_nxt : ram_addr_q;

    // A word pushed into an empty slot becomes the new head directly
    head_nxt = (push && (rd_ptr_nxt == wr_ptr_q)) ? bus.ram_q : mem_q[rd_ptr_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_nxt;
      rem_q      <= rem_nxt;
      pipe_q     <= pipe_nxt;
      wr_ptr_q   <= wr_ptr_nxt;
      rd_ptr_q   <= rd_ptr_nxt;
      cnt_q      <= cnt_nxt;
      ram_addr_q <= ram_addr_nxt;
      m_data_q   <= head_nxt;
      m_valid_q  <= (cnt_nxt != '0);
      busy_q     <= (state_nxt != S_IDLE);
      done_q     <= done_nxt;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.ram_q;
    end
  end

  // The credit rule must keep pushes away from a full FIFO
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (cnt_q == CNT_W'(FIFO_DEPTH))));
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = 1'b0;
  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Bench for dp_ram_stream_reader: directed bursts plus randomized bursts checked
// against a word-list reference model computed from RAM contents.
module tb_dp_ram_stream_reader;

  localparam int MAX_CYC = 1000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [15:0] ram_mem [256];
  logic [7:0]  ram_a_q;
  logic [15:0] ram_q_r;

  dp_ram_stream_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  dp_ram_stream_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .RD_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage registered-read RAM model: address register then output register
  always @(posedge clk) begin
    ram_a_q <= bus.ram_addr;
    ram_q_r <= ram_mem[ram_a_q];
  end
  assign bus.ram_q = ram_q_r;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready, 3 ready low for 20 cycles
  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode);
    logic [15:0] exp_q[$];
    logic [7:0]  addr_log [MAX_CYC+1];
    logic [7:0]  a;
    logic [7:0]  pre_addr;
    logic [15:0] prev_data;
    logic [31:0] exp_word;
    logic        prev_stall;
    int          first_valid;
    int          done_cycle;
    int          done_cnt;
    int          cyc;

    for (int i = 0; i < int'(len); i++) begin
      a = base + 8'(i);
      exp_q.push_back(ram_mem[a]);
    end
    first_valid = -1;
    done_cycle  = -1;
    done_cnt    = 0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    pre_addr    = bus.ram_addr;
    cyc         = 0;

    while (cyc < MAX_CYC) begin
      bus.start     = (cyc == 0);
      bus.base_addr = base;
      bus.length    = len;
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = (cyc >= 20);
      endcase
      @(negedge clk);
      addr_log[cyc] = bus.ram_addr;
      if (bus.done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      check("busy", 32'(bus.busy), 32'((len != 0) && (cyc >= 1) && (done_cycle < 0)));
      if (bus.m_valid && (first_valid < 0)) first_valid = cyc;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        exp_word = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
        check("word", 32'(bus.m_data), exp_word);
      end
      if ((mode == 3) && (cyc == 20)) begin
        a = base + 8'd3;
        check("stall_issue_addr", 32'(bus.ram_addr), 32'(a));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      @(posedge clk);
      #1;
      if ((done_cycle >= 0) && (cyc >= done_cycle + 2)) break;
      cyc++;
    end
    bus.start = 1'b0;

    check("done_seen", 32'(done_cycle >= 0), 32'd1);
    check("done_count", 32'(done_cnt), 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("first_valid_cycle", 32'(first_valid), (len == 0) ? 32'hFFFF_FFFF : 32'd4);
    if (len == 0) begin
      check("len0_done_cycle", 32'(done_cycle), 32'd1);
      check("len0_addr", 32'(bus.ram_addr), 32'(pre_addr));
      check("len0_addr_c1", 32'(addr_log[1]), 32'(pre_addr));
    end else if (mode == 0) begin
      check("done_cycle", 32'(done_cycle), 32'(4 + int'(len)));
      for (int i = 1; i <= int'(len); i++) begin
        a = base + 8'(i - 1);
        check("issue_addr", 32'(addr_log[i]), 32'(a));
      end
    end
  endtask

  initial begin
    int hs;
    int bad;
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'(i);

    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run_burst(8'h10, 9'd8, 0);
    run_burst(8'h10, 9'd8, 1);
    run_burst(8'hFE, 9'd4, 0);
    run_burst(8'h22, 9'd0, 0);
    run_burst(8'h00, 9'd256, 3);

    // Reset in the middle of a burst after three words are handed off
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      bus.start     = (c == 0);
      bus.base_addr = 8'h10;
      bus.length    = 9'd8;
      bus.m_ready   = 1'b1;
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) hs++;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("pre_reset_handshakes", 32'(hs), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check("midrst_m_data", 32'(bus.m_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done || bus.m_valid || bus.busy) bad++;
      @(posedge clk);
      #1;
    end
    check("post_reset_quiet", 32'(bad), 32'd0);
    run_burst(8'h40, 9'd2, 0);

    // Randomized contents, bases and lengths, including address wrap
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'($urandom);
    run_burst(8'($urandom), 9'($urandom_range(1, 40)), 0);
    for (int n = 0; n < 6; n++) begin
      run_burst(8'($urandom), 9'($urandom_range(1, 40)), 2);
    end
    run_burst(8'hF8, 9'd20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
